// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// It owns the PC and drives the address of an asynchronous-read instruction memory.
// Each returned word is captured into a 2-entry FIFO, which decode drains over a
// valid/ready handshake. Redirects flush the queue and reload the PC. A misaligned
// or out-of-range PC raises a fault, which is held until a redirect.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   fetch_en                     permits new fetches
//   imem_addr / imem_data        instruction memory byte address / returned word
//   redirect_valid / redirect_pc control-flow redirect pulse and target
//   inst_valid / inst_ready      queue head handshake to decode
//   inst_data / inst_pc          queue head word and its PC
//   fault / fault_pc             pending address fault and the offending PC
//
// state | meaning
// IDLE  | not fetching; queue drains
// FETCH | one fetch per cycle while the queue has room
// FAULT | bad PC seen; waits for a redirect, queue drains
module ifetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_pc
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMEM_DEPTH - 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] q0_data, q1_data;
  logic [ADDR_WIDTH-1:0] q0_pc, q1_pc;

  logic pop, push, set_fault, pc_illegal;

  assign imem_addr  = pc;
  assign inst_valid = (count != 2'd0);
  assign inst_data  = q0_data;
  assign inst_pc    = q0_pc;
  assign pop        = inst_valid & inst_ready;

  // The bound test rejects the PC before pc+4 could ever wrap back to a legal address.
  assign pc_illegal = (pc[1:0] != 2'b00) || (pc > LAST_ADDR);

  always_comb begin
    state_next = state;
    push       = 1'b0;
    set_fault  = 1'b0;
    if (redirect_valid) begin
      state_next = fetch_en ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) state_next = FETCH;
        end
        FETCH: begin
          if (!fetch_en) begin
            state_next = IDLE;
          end else if (pc_illegal) begin
            set_fault  = 1'b1;
            state_next = FAULT;
          end else if ((count != 2'd2) || pop) begin
            push = 1'b1;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      count    <= 2'd0;
      q0_data  <= '0;
      q0_pc    <= '0;
      q1_data  <= '0;
      q1_pc    <= '0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        // Any entry popped this cycle is taken by decode; everything else is dropped.
        pc    <= redirect_pc;
        count <= 2'd0;
        fault <= 1'b0;
      end else begin
        if (set_fault) begin
          fault    <= 1'b1;
          fault_pc <= pc;
        end
        if (push) pc <= pc + ADDR_WIDTH'(4);

        // Head always lives in entry 0; a pop shifts entry 1 forward.
        if (push && pop) begin
          if (count == 2'd2) begin
            q0_data <= q1_data;
            q0_pc   <= q1_pc;
            q1_data <= imem_data;
            q1_pc   <= pc;
          end else begin
            q0_data <= imem_data;
            q0_pc   <= pc;
          end
        end else if (push) begin
          if (count == 2'd0) begin
            q0_data <= imem_data;
            q0_pc   <= pc;
          end else begin
            q1_data <= imem_data;
            q1_pc   <= pc;
          end
          count <= count + 2'd1;
        end else if (pop) begin
          q0_data <= q1_data;
          q0_pc   <= q1_pc;
          count   <= count - 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the RV32I core. It owns the program counter and drives the byte address of the asynchronous-read instruction memory. It captures each 32-bit word the memory returns into a 2-entry fetch queue, which it presents to decode over a valid/ready handshake. It also handles control-flow redirects and raises an address fault when the PC is misaligned or falls outside the instruction memory.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC / instruction-memory byte-address width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_DEPTH, 256, instruction memory size in bytes; the last legal fetch address is IMEM_DEPTH-4

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- fetch_en  input  1  permits fetching; 0 stops new fetches, the queue keeps draining
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory; equals the PC register
- imem_data  input  DATA_WIDTH  word returned combinationally for imem_addr
- redirect_valid  input  1  branch/jump taken; single-cycle pulse
- redirect_pc  input  ADDR_WIDTH  target of the redirect
- inst_valid  output  1  queue head is valid
- inst_ready  input  1  decode accepts the head
- inst_data  output  DATA_WIDTH  head instruction word
- inst_pc  output  ADDR_WIDTH  PC of the head instruction
- fault  output  1  fetch address fault is pending
- fault_pc  output  ADDR_WIDTH  PC that caused the fault

## Operation
- State machine with three states: IDLE, FETCH and FAULT. Reset enters IDLE.
- **IDLE**
  - fetch_en=1 moves to FETCH at the next edge.
  - No push occurs in IDLE.
- **FETCH**
  - fetch_en=0 moves to IDLE at the next edge; no push that cycle.
  - A PC is illegal when pc[1:0]≠0 or pc > IMEM_DEPTH-4.
  - Illegal PC: no push. Set fault=1, load fault_pc=pc and move to FAULT.
  - Legal PC, with the queue not full or a pop occurring this cycle: push {pc, imem_data} and set pc ← pc+4.
  - Legal PC with the queue full and no pop: hold pc, no push.
- **FAULT**
  - No fetching; the queue continues to drain normally.
  - Exited only by redirect or reset.
- **Redirect** (any state; highest priority after reset)
  - Flush the queue and set pc ← redirect_pc. No push that cycle.
  - Clear fault.
  - Next state: FETCH if fetch_en=1, else IDLE.
  - A misaligned redirect target is accepted into pc; the fault is detected on the following FETCH cycle.
- **Queue**
  - 2 entries, FIFO order.
  - Pop = inst_valid & inst_ready.
  - Simultaneous push and pop is legal at every occupancy, including full.
  - Occupancy never exceeds 2 and never underflows.
- **Arithmetic:** pc+4 wraps modulo 2^ADDR_WIDTH. The bound check catches the wrap before any push.

## Timing
- **Reset values:**
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - Queue empty: inst_valid=0.
  - inst_data=0, inst_pc=0.
  - fault=0, fault_pc=0.
  - State IDLE.
- **Outputs:**
  - imem_addr is registered (the pc register).
  - inst_* come from queue registers.
  - fault and fault_pc are registered.
  - inst_data and inst_pc are don't-care while inst_valid=0.
- **Startup latency:** rst falls before edge E0, with fetch_en=1.
  - E0: IDLE→FETCH.
  - E1: first push; inst_valid=1 with inst_pc=RESET_PC after E1.
- **Sustained throughput:** one instruction per cycle while inst_ready=1.
- **Redirect latency:** redirect sampled at edge E.
  - Queue empty and pc=target after E.
  - First target instruction is valid after E+1.
- **Flush:** the entry popped in the redirect cycle counts as accepted. Queued wrong-path entries are discarded and are never presented after the redirect edge.
- **Reset mid-operation:** rst has priority over redirect and push. Everything returns to its reset values at the next edge.
- **Handshake:** while inst_valid=1 and inst_ready=0, inst_data and inst_pc are held stable.

## Test plan
- **Reset/stream:**
  - Stimulus: RESET_PC=0, memory words 0x00000013, 0x00100093, …; fetch_en=1, inst_ready=1.
  - Required: inst_valid rises after E1; inst_pc reads 0, 4, 8, … on consecutive cycles with matching data.
- **Backpressure:**
  - Stimulus: inst_ready=0 for 5 cycles.
  - Required: queue holds pc 0 and 4; imem_addr stays at 8; on release, pc 0, 4, 8 are delivered in order with no loss or duplicate.
- **Redirect flush:**
  - Stimulus: redirect_pc=0x40 pulsed with the queue full (pc 8, 12).
  - Required: the next inst_valid presents inst_pc=0x40 one cycle later; 8 and 12 never appear.
- **Bound fault:**
  - Stimulus: stream until pc=0x100 with IMEM_DEPTH=256.
  - Required: last delivered inst_pc=0xFC; fault=1 with fault_pc=0x100; no further pushes. A subsequent redirect to 0x10 clears fault and resumes at 0x10.
- **Misalignment and precedence:**
  - Stimulus: redirect_pc=0x22.
  - Required: fault=1, fault_pc=0x22, with nothing pushed.
  - Stimulus: assert rst and redirect in the same cycle.
  - Required: pc=RESET_PC; queue empty.
